mux4way_stream_arbiter: RTL
===========================

Name: mux4way_stream_arbiter

Overview:
- Collecting counterpart to the DMux4Way fan-out. Merges four independent valid/ready word streams onto one output stream.
- Arbitration is round-robin with packet locking. Each output beat is tagged with the 2-bit source index (out_sel) so a downstream DMux4Way-style router can steer responses back.
- Sits between four Hack-word producers and a single shared consumer. It has a one-entry registered output stage.

Parameters:
- WIDTH, 16, data word width in bits (Hack word).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-channel beat valid; bit i belongs to channel i.
- in_data  input  4*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- in_last  input  4  per-channel end-of-packet marker for the current beat.
- in_ready  output  4  per-channel accept; at most one bit high in any cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  held beat data.
- out_last  output  1  held beat is the last beat of its packet.
- out_sel  output  2  source channel index of the held beat.
- out_ready  input  1  consumer accepts the held beat.

Behaviour:
- Handshake rules:
  - A transfer occurs on any edge where valid and ready are both high.
  - Producers must not deassert valid or change data/last until accepted.
  - The consumer side obeys the same rule for out_*.
- Reset values: while reset is high, and immediately on assertion (async), out_valid=0, out_data=0, out_last=0, out_sel=0, in_ready=4'b0000. Internal state: rr_ptr=0, state=IDLE, lock_ch=0.
- can_load = !out_valid | out_ready. The output register can take a new beat this cycle.
- State machine:
  - IDLE: candidate = first channel with in_valid=1, searching rr_ptr, rr_ptr+1, ... (mod 4). in_ready[candidate] = can_load; all other in_ready bits 0. With no valid channel, in_ready=0000.
  - On an accepted beat from channel g in IDLE:
    - If in_last[g]=1: stay IDLE, rr_ptr <= g+1 mod 4.
    - If in_last[g]=0: go to LOCKED, lock_ch <= g; rr_ptr unchanged.
  - LOCKED: only lock_ch is eligible. in_ready[lock_ch] = can_load; other channels are ignored even if valid.
  - On an accepted beat with in_last=1 in LOCKED: go to IDLE, rr_ptr <= lock_ch+1 mod 4.
- Output register:
  - On an accepted input beat, out_valid<=1, out_data<=beat data, out_last<=in_last, out_sel<=channel index.
  - Otherwise, if out_ready & out_valid, out_valid<=0 and data/last/sel hold their last value.
- Latency and throughput: 1 cycle from input accept to out_valid. Sustained throughput is 1 beat/cycle when out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, out_* are stable and in_ready=0000.
- in_ready depends combinationally on in_valid, state and out_ready. Producers' in_valid must not depend on in_ready.
- Simultaneous output drain and input load in one cycle is legal. The new beat replaces the drained one with no bubble.
- Reset mid-operation: any held beat and any locked packet are discarded; arbitration restarts at channel 0.
- Wrap-around: rr_ptr increments modulo 4 (3 -> 0).
- A packet of a single beat (last=1 on first beat) never enters LOCKED.

Test Plan:
- Reset: hold reset high with all in_valid=1 -> in_ready=0000, out_valid=0, out_sel=0, out_data=0. Assert reset asynchronously mid-cycle -> outputs clear before the next edge.
- Single beat: ch2 in_valid=1, in_data=16'h1234, in_last=1, out_ready=1 -> in_ready=0100 that cycle. Next cycle out_valid=1, out_data=16'h1234, out_sel=2, out_last=1. A subsequent ch2-only beat is still granted (rr_ptr=3 wraps to 2).
- Fairness: all four channels continuously valid with single-beat packets, out_ready=1 from reset -> out_sel sequence 0,1,2,3,0,1, one beat per cycle, no gaps.
- Locking: ch1 sends 16'h00A0, 16'h00A1, 16'h00A2 (last on third) while ch0 and ch3 stay valid -> out_sel 1,1,1 with data A0,A1,A2 in order. Then 3, then 0; ch0/ch3 in_ready stay 0 during the packet.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1, out_data=16'h0055 -> out_data stable, in_ready=0000. Raise out_ready -> 16'h0055 accepted exactly once, next beat follows next cycle; no loss or duplication.
- Reset while LOCKED on ch3 after 1 of 3 beats -> out_valid=0 immediately. After release with ch0 and ch3 valid, ch0 is granted first.

Source files
------------

// File: rtl/mux4way_stream_arbiter.sv
// Four-to-one valid/ready stream merger: round-robin arbitration with packet
// locking, feeding a one-entry output register tagged with the source channel.
module mux4way_stream_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_last,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [1:0]         out_sel,
    input  logic               out_ready
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       lock_ch_q, lock_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [1:0]       out_sel_q, out_sel_d;

    logic             can_load;
    logic             grant_vld;
    logic [1:0]       grant_ch;
    logic [1:0]       idx;
    logic             accept;
    logic [WIDTH-1:0] ch_data [4];

    for (genvar i = 0; i < 4; i++) begin : g_slice
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign can_load = !out_valid_q || out_ready;

    // Scan offsets from 3 down to 0 so the channel closest to rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = rr_ptr_q;
        idx       = rr_ptr_q;
        if (state_q == LOCKED) begin
            grant_vld = in_valid[lock_ch_q];
            grant_ch  = lock_ch_q;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                idx = rr_ptr_q + 2'(k);
                if (in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_ch  = idx;
                end
            end
        end
    end

    // in_ready is held low for the whole reset window, not just after it.
    assign accept   = grant_vld && can_load && !reset;
    assign in_ready = accept ? (4'b0001 << grant_ch) : 4'b0000;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_ch_d   = lock_ch_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[grant_ch];
            out_last_d  = in_last[grant_ch];
            out_sel_d   = grant_ch;
            if (in_last[grant_ch]) begin
                state_d  = IDLE;
                rr_ptr_d = grant_ch + 2'd1;
            end else begin
                state_d   = LOCKED;
                lock_ch_d = grant_ch;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 2'd0;
            lock_ch_q   <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_ch_q   <= lock_ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
endmodule
